// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
//               MULT/MULTU use radix-2 shift-add, DIV/DIVU use a restoring
//               divider. Both run on operand magnitudes for exactly WIDTH
//               iterations, with sign correction applied at write-back.
//               MTHI/MTLO write HI/LO directly while the unit is idle.
//               MFHI/MFLO are read combinationally through rd_data.
// Ports       : clk, resetn (async, active-low)
//               op, funct, valid, cancel, rs_data, rt_data  - instruction in
//               rd_data                                     - MFHI/MFLO result
//               hi, lo                                      - architectural HI/LO
//               stall, busy, done                           - pipeline handshake
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic             cancel,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // ---------------- decode ----------------
    logic is_special, is_mul, is_div, is_md, is_mthi, is_mtlo, signed_op;
    assign is_special = valid && (op == 6'b000000);
    assign is_mul     = is_special && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
    assign is_div     = is_special && ((funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
    assign is_md      = is_mul || is_div;
    assign is_mthi    = is_special && (funct == FUNCT_MTHI);
    assign is_mtlo    = is_special && (funct == FUNCT_MTLO);
    // The signed variants are the even funct codes.
    assign signed_op  = ~funct[0];

    always_comb begin
        rd_data = '0;
        if (is_special && (funct == FUNCT_MFHI)) rd_data = hi;
        if (is_special && (funct == FUNCT_MFLO)) rd_data = lo;
    end

    // ---------------- operand magnitudes at acceptance ----------------
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    assign rs_neg = signed_op && rs_data[WIDTH-1];
    assign rt_neg = signed_op && rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? (~rs_data + 1'b1) : rs_data;
    assign rt_mag = rt_neg ? (~rt_data + 1'b1) : rt_data;

    // ---------------- latched operation context ----------------
    logic             md_div;     // 1: divide, 0: multiply
    logic             neg_res;    // negate product / quotient
    logic             neg_rem;    // negate remainder (dividend sign)
    logic             div_zero;
    logic [WIDTH-1:0] rs_hold;    // raw dividend, returned in HI on divide-by-zero
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits -> quotient
    logic [CNT_W-1:0] cnt;

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi_n, div_lo_n;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n  = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // The partial remainder is always below the divisor, so after a
    // successful subtract the difference fits in WIDTH bits.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;
    assign div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};

    assign step_hi   = md_div ? div_hi_n : mul_hi_n;
    assign step_lo   = md_div ? div_lo_n : mul_lo_n;

    // ---------------- sign-corrected result ----------------
    // Most-negative / -1 needs no special path: |MIN| / 1 = MIN, and
    // negating MIN yields MIN again, with a zero remainder.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;
    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_res ? (~prod + 1'b1) : prod;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (md_div) begin
            res_lo = neg_res ? (~step_lo + 1'b1) : step_lo;
            res_hi = neg_rem ? (~step_hi + 1'b1) : step_hi;
            if (div_zero) begin
                res_lo = '1;
                res_hi = rs_hold;
            end
        end
    end

    logic calc_last;
    assign calc_last = (cnt == CNT_W'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (is_md && !cancel) begin
                    next_state = CALC;
                    stall      = 1'b1;
                end
            end
            CALC: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (cancel)         next_state = IDLE;
                else if (calc_last) next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi       <= '0;
            lo       <= '0;
            md_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            rs_hold  <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!cancel) begin
                        if (is_md) begin
                            md_div   <= is_div;
                            neg_res  <= rs_neg ^ rt_neg;
                            neg_rem  <= rs_neg;
                            div_zero <= (rt_data == '0);
                            rs_hold  <= rs_data;
                            acc_hi   <= '0;
                            opnd     <= is_div ? rt_mag : rs_mag;
                            acc_lo   <= is_div ? rs_mag : rt_mag;
                        end
                        if (is_mthi) hi <= rs_data;
                        if (is_mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 1'b1;
                        if (calc_last) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
